// File: rtl/if_id.sv
// IF/ID pipeline register with load-use hazard detection and branch flush.
// Optional perf counters (stallCount/flushCount) enabled by defining IF_ID_PERF_CNT_EN.
module if_id #(
    parameter int WORD_BITWIDTH    = 32,
    parameter int REG_NUM_BITWIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WORD_BITWIDTH-1:0]    if_pc,
    input  logic [31:0]                 if_inst,
    input  logic                        if_valid,
    input  logic                        branchTaken,
    input  logic                        ex_memRead,
    input  logic [REG_NUM_BITWIDTH-1:0] ex_regToWrite,
    output logic [WORD_BITWIDTH-1:0]    id_pc,
    output logic [31:0]                 id_inst,
    output logic                        id_valid,
    output logic [6:0]                  id_opcode,
    output logic [REG_NUM_BITWIDTH-1:0] id_Rs1,
    output logic [REG_NUM_BITWIDTH-1:0] id_Rs2,
    output logic [REG_NUM_BITWIDTH-1:0] id_rd,
    output logic                        hazard,
    output logic                        pcWrite,
    output logic [31:0]                 stallCount,
    output logic [31:0]                 flushCount
);

    localparam logic [31:0] NOP_INST = 32'h00000013;

    logic [WORD_BITWIDTH-1:0] r_pc;
    logic [31:0]              r_inst;
    logic                     r_valid;

    logic                     w_uses_rs1;
    logic                     w_uses_rs2;
    logic                     w_raw_hazard;
    logic                     w_hazard;

    assign id_pc     = r_pc;
    assign id_inst   = r_inst;
    assign id_valid  = r_valid;
    assign id_opcode = r_inst[6:0];
    assign id_Rs1    = REG_NUM_BITWIDTH'(r_inst[19:15]);
    assign id_Rs2    = REG_NUM_BITWIDTH'(r_inst[24:20]);
    assign id_rd     = REG_NUM_BITWIDTH'(r_inst[11:7]);

    always_comb begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b0;
        case (r_inst[6:0])
            7'b0110111, 7'b0010111, 7'b1101111: w_uses_rs1 = 1'b0;
            default:                            w_uses_rs1 = 1'b1;
        endcase
        case (r_inst[6:0])
            7'b0110011, 7'b0100011, 7'b1100011: w_uses_rs2 = 1'b1;
            default:                            w_uses_rs2 = 1'b0;
        endcase
    end

    assign w_raw_hazard = r_valid && ex_memRead && (ex_regToWrite != '0) &&
                          ((w_uses_rs1 && (ex_regToWrite == id_Rs1)) ||
                           (w_uses_rs2 && (ex_regToWrite == id_Rs2)));
    // A taken branch squashes ID anyway, so the stall is dropped and fetch takes the redirect.
    assign w_hazard = w_raw_hazard && !branchTaken;
    assign hazard   = w_hazard;
    assign pcWrite  = !w_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (branchTaken) begin
            r_pc    <= '0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (!w_hazard) begin
            r_pc <= if_pc;
            if (if_valid) begin
                r_inst  <= if_inst;
                r_valid <= 1'b1;
            end else begin
                r_inst  <= NOP_INST;
                r_valid <= 1'b0;
            end
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_hazard && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (branchTaken && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stallCount = r_stall_cnt;
    assign flushCount = r_flush_cnt;
`else
    assign stallCount = '0;
    assign flushCount = '0;
`endif

endmodule

// File: tb/tb_if_id.sv
// Directed self-checking bench for if_id; perf-counter checks follow IF_ID_PERF_CNT_EN.
module tb_if_id;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        branchTaken;
    logic        ex_memRead;
    logic [4:0]  ex_regToWrite;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_Rs1;
    logic [4:0]  id_Rs2;
    logic [4:0]  id_rd;
    logic        hazard;
    logic        pcWrite;
    logic [31:0] stallCount;
    logic [31:0] flushCount;

    int unsigned n_tests;
    int unsigned n_fail;
    logic [31:0] stall_before;
    logic [31:0] flush_before;

    if_id #(.WORD_BITWIDTH(32), .REG_NUM_BITWIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
        .branchTaken(branchTaken), .ex_memRead(ex_memRead), .ex_regToWrite(ex_regToWrite),
        .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_Rs1(id_Rs1), .id_Rs2(id_Rs2), .id_rd(id_rd),
        .hazard(hazard), .pcWrite(pcWrite),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; if_pc = '0; if_inst = 32'h13; if_valid = 1'b0;
        branchTaken = 1'b0; ex_memRead = 1'b0; ex_regToWrite = '0;
        step(); step();
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_inst", id_inst, 32'h00000013);
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_opcode", {25'b0, id_opcode}, 32'h13);
        chk("rst_pcwrite", {31'b0, pcWrite}, 32'h1);
        chk("rst_stall", stallCount, 32'h0);
        rst_n = 1'b1;

        // Normal flow: addi x1,x0,5
        if_pc = 32'h100; if_inst = 32'h00500093; if_valid = 1'b1;
        step();
        chk("nf_pc", id_pc, 32'h100);
        chk("nf_rd", {27'b0, id_rd}, 32'h1);
        chk("nf_rs1", {27'b0, id_Rs1}, 32'h0);
        chk("nf_valid", {31'b0, id_valid}, 32'h1);
        chk("nf_hazard", {31'b0, hazard}, 32'h0);

        // Load-use on Rs2 of add x3,x1,x2
        if_pc = 32'h104; if_inst = 32'h002081B3;
        step();
        chk("lu_rs2field", {27'b0, id_Rs2}, 32'h2);
        ex_memRead = 1'b1; ex_regToWrite = 5'd2;
        if_pc = 32'h108; if_inst = 32'h00000093;
        #1;
        chk("lu_hazard", {31'b0, hazard}, 32'h1);
        chk("lu_pcwrite", {31'b0, pcWrite}, 32'h0);
        ex_regToWrite = 5'd0; #1;
        chk("lu_x0_nohaz", {31'b0, hazard}, 32'h0);
        ex_regToWrite = 5'd1; #1;
        chk("lu_rs1_haz", {31'b0, hazard}, 32'h1);
        ex_regToWrite = 5'd2; #1;
        stall_before = stallCount;
        step();
        chk("lu_hold_pc", id_pc, 32'h104);
        chk("lu_hold_inst", id_inst, 32'h002081B3);
`ifdef IF_ID_PERF_CNT_EN
        chk("lu_stallcnt", stallCount, stall_before + 32'd1);
`else
        chk("lu_stallcnt_off", stallCount, 32'h0);
`endif
        // Bubble in EX clears memRead; held instruction advances
        ex_memRead = 1'b0; #1;
        chk("lu_release", {31'b0, hazard}, 32'h0);
        step();
        chk("lu_adv_pc", id_pc, 32'h108);

        // addi x3,x1,2: Rs2 field is x2 but not a source
        if_pc = 32'h10C; if_inst = 32'h00208193;
        step();
        ex_memRead = 1'b1; ex_regToWrite = 5'd2; #1;
        chk("rs2unused", {31'b0, hazard}, 32'h0);
        ex_regToWrite = 5'd1; #1;
        chk("addi_rs1_haz", {31'b0, hazard}, 32'h1);

        // Flush beats hazard
        branchTaken = 1'b1; #1;
        chk("fl_hazard", {31'b0, hazard}, 32'h0);
        chk("fl_pcwrite", {31'b0, pcWrite}, 32'h1);
        stall_before = stallCount;
        flush_before = flushCount;
        step();
        branchTaken = 1'b0;
        chk("fl_valid", {31'b0, id_valid}, 32'h0);
        chk("fl_inst", id_inst, 32'h00000013);
        chk("fl_pc", id_pc, 32'h0);
`ifdef IF_ID_PERF_CNT_EN
        chk("fl_flushcnt", flushCount, flush_before + 32'd1);
        chk("fl_stallcnt", stallCount, stall_before);
`else
        chk("fl_flushcnt_off", flushCount, 32'h0);
`endif

        // Invalid fetch loads NOP but keeps the PC
        ex_memRead = 1'b0;
        if_pc = 32'h200; if_valid = 1'b0;
        step();
        chk("iv_pc", id_pc, 32'h200);
        chk("iv_valid", {31'b0, id_valid}, 32'h0);
        chk("iv_inst", id_inst, 32'h00000013);

`ifdef IF_ID_PERF_CNT_EN
        // Saturation: hold a load-use stall for three edges
        if_valid = 1'b1; if_pc = 32'h300; if_inst = 32'h00208193;
        step();
        ex_memRead = 1'b1; ex_regToWrite = 5'd1;
        force dut.r_stall_cnt = 32'hFFFFFFFE;
        #1;
        release dut.r_stall_cnt;
        #1;
        chk("sat_preset", stallCount, 32'hFFFFFFFE);
        step(); step(); step();
        chk("sat_final", stallCount, 32'hFFFFFFFF);
        ex_memRead = 1'b0;
`endif

        // Asynchronous reset mid-stream
        if_valid = 1'b1; if_pc = 32'h400; if_inst = 32'h00500093;
        step();
        chk("ar_pre_valid", {31'b0, id_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, id_valid}, 32'h0);
        chk("ar_inst", id_inst, 32'h00000013);
        chk("ar_pc", id_pc, 32'h0);
        chk("ar_pcwrite", {31'b0, pcWrite}, 32'h1);
        chk("ar_stall", stallCount, 32'h0);
        step();
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id.md
# if_id

IF/ID pipeline register with integrated load-use hazard detection and branch flush, sitting between instruction fetch and decode. It captures the fetched PC/instruction, exposes decoded register fields to decode, and generates the `hazard` bubble request consumed by the ID/EX register together with the PC write-enable for fetch. It detects load-use hazards against the instruction currently in EX, using the ID/EX outputs. It stalls for exactly one cycle per load-use hazard and squashes its contents on a taken branch.

## Interface
Parameters:
- `WORD_BITWIDTH`, 32, PC/data width
- `REG_NUM_BITWIDTH`, 5, register index width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_pc`  in  WORD_BITWIDTH  PC of fetched instruction
- `if_inst`  in  32  fetched instruction word
- `if_valid`  in  1  fetched instruction is valid
- `branchTaken`  in  1  taken branch/jump resolved downstream; flush
- `ex_memRead`  in  1  instruction in EX is a load (ID/EX `ex_wt_memRead`)
- `ex_regToWrite`  in  REG_NUM_BITWIDTH  destination of instruction in EX (ID/EX `ex_wt_regToWrite`)
- `id_pc`  out  WORD_BITWIDTH  registered PC
- `id_inst`  out  32  registered instruction
- `id_valid`  out  1  registered valid
- `id_opcode`  out  7  `id_inst[6:0]`
- `id_Rs1`  out  REG_NUM_BITWIDTH  `id_inst[19:15]`
- `id_Rs2`  out  REG_NUM_BITWIDTH  `id_inst[24:20]`
- `id_rd`  out  REG_NUM_BITWIDTH  `id_inst[11:7]`
- `hazard`  out  1  insert bubble into ID/EX this cycle
- `pcWrite`  out  1  fetch may advance PC
- `stallCount`  out  32  cycles with `hazard`=1 (perf)
- `flushCount`  out  32  cycles with `branchTaken`=1 (perf)

## Operation
- Register state: `id_pc`, `id_inst`, `id_valid`, plus counters. Field outputs are combinational slices of `id_inst`.
- Source usage is decoded from `id_opcode`:
  - usesRs1 = 0 for LUI 0110111, AUIPC 0010111, JAL 1101111; 1 otherwise.
  - usesRs2 = 1 only for R-type 0110011, store 0100011, branch 1100011.
- rawHazard = `id_valid` & `ex_memRead` & (`ex_regToWrite` != 0) & ((usesRs1 & `ex_regToWrite`==`id_Rs1`) | (usesRs2 & `ex_regToWrite`==`id_Rs2`)).
- `hazard` = rawHazard & ~`branchTaken`.
- `pcWrite` = ~`hazard`.
- Next-state priority, highest first:
  1. `branchTaken`: `id_inst`<=32'h00000013 (NOP), `id_valid`<=0, `id_pc`<=0.
  2. `hazard`: hold all registers.
  3. `if_valid`=0: load NOP, `id_valid`<=0, `id_pc`<=`if_pc`.
  4. Otherwise: load `if_pc`, `if_inst`, `id_valid`<=1.
- Load-use stall is self-terminating. The bubble reaching EX clears `ex_memRead`, so `hazard` deasserts the following cycle. The held instruction then advances with the freshly fetched one behind it.
- Simultaneous `branchTaken` and rawHazard: flush wins, `hazard`=0, `pcWrite`=1 so fetch takes the redirect.
- Reset mid-operation clears all state immediately, regardless of clock.

## Timing
- Reset values:
  - `id_pc`=0, `id_inst`=32'h00000013, `id_valid`=0, so `id_opcode`=7'h13, `id_Rs1`=0, `id_Rs2`=0, `id_rd`=0.
  - `hazard`=0, `pcWrite`=1, `stallCount`=0, `flushCount`=0.
- Latency: `if_*` to `id_*` is one cycle.
- `hazard`/`pcWrite` are combinational from registered `id_*`, `ex_memRead`, `ex_regToWrite`, and `branchTaken`. There is no combinational path from `if_*`.
- A load-use pair produces exactly one cycle of `hazard`=1 and `pcWrite`=0.
- Counters increment on the clock edge ending a qualifying cycle and saturate at 32'hFFFFFFFF (no wrap).

## Configuration
- `IF_ID_PERF_CNT_EN` defined: `stallCount`/`flushCount` are implemented as described.
- Not defined: counter registers are omitted and both ports are constant 0. All other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 mid-stream with `id_valid`=1. Required: outputs immediately return to reset values; `id_inst`=32'h00000013, `pcWrite`=1.
- Normal flow: `if_pc`=0x100, `if_inst`=0x00500093, `if_valid`=1. Required: next cycle `id_pc`=0x100, `id_rd`=1, `id_Rs1`=0, `id_valid`=1, `hazard`=0.
- Load-use: `id_inst`=0x002081B3 (add x3,x1,x2), `ex_memRead`=1, `ex_regToWrite`=2.
  - Required: `hazard`=1 and `pcWrite`=0 for one cycle, with registers held.
  - With `ex_regToWrite`=0 or `ex_memRead`=0: `hazard`=0.
- Rs2 not used: `id_inst`=0x00208193 (addi), `ex_memRead`=1, `ex_regToWrite`=2. Required: `hazard`=0.
- Flush priority: hazard condition present and `branchTaken`=1 in the same cycle.
  - Required: `hazard`=0, `pcWrite`=1.
  - Next cycle: `id_valid`=0, `id_inst`=0x00000013.
  - With `IF_ID_PERF_CNT_EN`: `flushCount` increments by 1 and `stallCount` is unchanged.
- Saturation (`IF_ID_PERF_CNT_EN`): force `stallCount` to 32'hFFFFFFFE, then trigger 3 stall cycles. Required: final `stallCount`=32'hFFFFFFFF.
